pong_game_ctrl: RTL and testbench

- Game sequencer for the VGA pong datapath.
- Decides when the ball is frozen at centre or free to move, and which direction it serves.
- Counts points from per-side miss events and declares a winner.
- Sits beside the ball/paddle logic; consumes the once-per-frame update strobe and drives hold/serve controls into the ball-position update.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/pong_edge_detect.sv | 27 ++
 rtl/pong_game_ctrl.sv | 152 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong game sequencer: state codes, serve directions
// and default parameter values.
package pong_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SERVE = 3'd1;
  localparam state_t ST_PLAY  = 3'd2;
  localparam state_t ST_POINT = 3'd3;
  localparam state_t ST_OVER  = 3'd4;
  localparam state_t ST_PAUSE = 3'd5;

  localparam logic DIR_TO_P2 = 1'b0;
  localparam logic DIR_TO_P1 = 1'b1;

  localparam int DEF_SERVE_DELAY_FRAMES = 60;
  localparam int DEF_WIN_SCORE          = 7;
  localparam int DEF_SCORE_W            = 4;

endpackage

// File: rtl/pong_edge_detect.sv
// Registered rising-edge detector: one single-cycle pulse per low-to-high
// transition of an already-synchronised level input.
module pong_edge_detect
  import pong_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sig_q   <= sig_i;
      pulse_q <= sig_i & ~sig_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve hold-off, point scoring and winner detection.
// Define PONG_GAME_CTRL_PAUSE_EN to let start presses pause and resume play.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_DELAY_FRAMES = DEF_SERVE_DELAY_FRAMES,
  parameter int WIN_SCORE          = DEF_WIN_SCORE,
  parameter int SCORE_W            = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_start,
  input  logic               miss_p1,
  input  logic               miss_p2,
  output logic               ball_hold,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [2:0]         game_state,
  output logic               game_over,
  output logic               winner
);

`ifdef PONG_GAME_CTRL_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam logic [7:0]         LAST_FRAME = 8'(SERVE_DELAY_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_Q      = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  logic start_pulse;

  pong_edge_detect u_start_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (btn_start),
    .pulse_o(start_pulse)
  );

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d;
  logic [SCORE_W-1:0] s2_q, s2_d;
  logic               dir_q, dir_d;
  logic               win_q, win_d;
  logic               hold_q, hold_d;
  logic               over_q, over_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dir_d   = dir_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_pulse) begin
          state_d = ST_SERVE;
          cnt_d   = 8'd0;
          s1_d    = '0;
          s2_d    = '0;
          dir_d   = DIR_TO_P2;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == LAST_FRAME) begin
            state_d = ST_PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_PLAY: begin
        // A simultaneous double miss is a replay: no score, same server.
        if (miss_p1 && miss_p2) begin
          state_d = ST_POINT;
        end else if (miss_p1) begin
          s2_d    = sat_inc(s2_q);
          dir_d   = DIR_TO_P1;
          state_d = ST_POINT;
        end else if (miss_p2) begin
          s1_d    = sat_inc(s1_q);
          dir_d   = DIR_TO_P2;
          state_d = ST_POINT;
        end else if (PAUSE_EN && start_pulse) begin
          state_d = ST_PAUSE;
        end
      end
      ST_POINT: begin
        cnt_d = 8'd0;
        if (s1_q == WIN_Q) begin
          state_d = ST_OVER;
          win_d   = 1'b0;
        end else if (s2_q == WIN_Q) begin
          state_d = ST_OVER;
          win_d   = 1'b1;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_PAUSE: begin
        if (start_pulse) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flags follow the next state so they change on the same edge as game_state.
    hold_d = (state_d != ST_PLAY);
    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      s1_q    <= '0;
      s2_q    <= '0;
      dir_q   <= DIR_TO_P2;
      win_q   <= 1'b0;
      hold_q  <= 1'b1;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      hold_q  <= hold_d;
      over_q  <= over_d;
    end
  end

  assign ball_hold  = hold_q;
  assign serve_dir  = dir_q;
  assign score_p1   = s1_q;
  assign score_p2   = s2_q;
  assign game_state = state_q;
  assign game_over  = over_q;
  assign winner     = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: two instances (short and long games) checked every
// cycle against a game-rule model, plus a vector table and corner sequences.
module tb_pong_game_ctrl;

  localparam int SD = 3;
  localparam int WA = 2;
  localparam int WB = 7;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0, frame_tick = 1'b0, btn_start = 1'b0, miss_p1 = 1'b0, miss_p2 = 1'b0;

  logic          hold_a, dir_a, over_a, win_a, hold_b, dir_b, over_b, win_b;
  logic [SW-1:0] s1_a, s2_a, s1_b, s2_b;
  logic [2:0]    st_a, st_b;

  always #5 clk = ~clk;

  pong_game_ctrl #(.SERVE_DELAY_FRAMES(SD), .WIN_SCORE(WA), .SCORE_W(SW)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_start(btn_start),
    .miss_p1(miss_p1), .miss_p2(miss_p2), .ball_hold(hold_a), .serve_dir(dir_a),
    .score_p1(s1_a), .score_p2(s2_a), .game_state(st_a), .game_over(over_a), .winner(win_a));

  pong_game_ctrl #(.SERVE_DELAY_FRAMES(SD), .WIN_SCORE(WB), .SCORE_W(SW)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_start(btn_start),
    .miss_p1(miss_p1), .miss_p2(miss_p2), .ball_hold(hold_b), .serve_dir(dir_b),
    .score_p1(s1_b), .score_p2(s2_b), .game_state(st_b), .game_over(over_b), .winner(win_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Game-rule model: phase 0 idle, 1 serve, 2 play, 3 point, 4 over, 5 pause.
  typedef struct {
    int ph;
    int cnt;
    int s1;
    int s2;
    int dir;
    int win;
  } mdl_t;

  mdl_t ma = '{0, 0, 0, 0, 0, 0};
  mdl_t mb = '{0, 0, 0, 0, 0, 0};
  bit   btn_prev = 1'b0;
  bit   pulse_m = 1'b0;
  bit   chk_en = 1'b0;

  function automatic int sat(input int x);
    return (x > (1 << SW) - 1) ? (1 << SW) - 1 : x;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int winsc, input bit rst,
                                 input bit pulse, input bit tick, input bit m1, input bit m2);
    mdl_t n;
    bit   pause_en;
    n = m;
`ifdef PONG_GAME_CTRL_PAUSE_EN
    pause_en = 1'b1;
`else
    pause_en = 1'b0;
`endif
    if (rst) return '{0, 0, 0, 0, 0, 0};
    case (m.ph)
      0, 4: if (pulse) n = '{1, 0, 0, 0, 0, m.win};
      1: if (tick) begin
        n.cnt = m.cnt + 1;
        if (n.cnt == SD) begin
          n.ph  = 2;
          n.cnt = 0;
        end
      end
      2: begin
        if (m1 || m2) n.ph = 3;
        if (m1 && !m2) begin
          n.s2  = sat(m.s2 + 1);
          n.dir = 1;
        end else if (m2 && !m1) begin
          n.s1  = sat(m.s1 + 1);
          n.dir = 0;
        end else if (!m1 && !m2 && pulse && pause_en) begin
          n.ph = 5;
        end
      end
      3: begin
        n.cnt = 0;
        n.ph  = (m.s1 == winsc || m.s2 == winsc) ? 4 : 1;
        if (m.s1 == winsc) n.win = 0;
        else if (m.s2 == winsc) n.win = 1;
      end
      5: if (pulse) n.ph = 2;
      default: n.ph = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    ma       <= mstep(ma, WA, !rst_n, pulse_m, frame_tick, miss_p1, miss_p2);
    mb       <= mstep(mb, WB, !rst_n, pulse_m, frame_tick, miss_p1, miss_p2);
    pulse_m  <= rst_n & btn_start & ~btn_prev;
    btn_prev <= rst_n & btn_start;
  end

  task automatic chk_model(input string tag, input mdl_t m, input logic [2:0] st,
                           input logic hold, input logic dir, input logic [SW-1:0] s1,
                           input logic [SW-1:0] s2, input logic over, input logic win);
    chk({tag, ".game_state"}, int'(st), m.ph);
    chk({tag, ".ball_hold"}, int'(hold), (m.ph != 2) ? 1 : 0);
    chk({tag, ".serve_dir"}, int'(dir), m.dir);
    chk({tag, ".score_p1"}, int'(s1), m.s1);
    chk({tag, ".score_p2"}, int'(s2), m.s2);
    chk({tag, ".game_over"}, int'(over), (m.ph == 4) ? 1 : 0);
    if (m.ph == 4) chk({tag, ".winner"}, int'(win), m.win);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk_model("A", ma, st_a, hold_a, dir_a, s1_a, s2_a, over_a, win_a);
      chk_model("B", mb, st_b, hold_b, dir_b, s1_b, s2_b, over_b, win_b);
    end
  end

  typedef struct {
    bit rst_n;
    bit btn;
    bit tick;
    bit m1;
    bit m2;
    int st;
    bit hold;
    int s1;
    int s2;
    bit dir;
  } vec_t;

  vec_t tbl[22];

  task automatic cyc(input bit b, input bit t, input bit m1, input bit m2);
    btn_start  = b;
    frame_tick = t;
    miss_p1    = m1;
    miss_p2    = m2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 0, 0, 2, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 2, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 1, 0, 1, 3, 1, 1, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[10] = '{1, 1, 0, 1, 0, 1, 1, 1, 0, 0};
    tbl[11] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0};
    tbl[12] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 0};
    tbl[13] = '{1, 0, 1, 0, 0, 2, 0, 1, 0, 0};
    tbl[14] = '{1, 0, 0, 1, 0, 3, 1, 1, 1, 1};
    tbl[15] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    tbl[16] = '{1, 0, 1, 0, 0, 1, 1, 1, 1, 1};
    tbl[17] = '{1, 0, 1, 0, 0, 1, 1, 1, 1, 1};
    tbl[18] = '{1, 0, 1, 0, 0, 2, 0, 1, 1, 1};
    tbl[19] = '{1, 0, 0, 1, 1, 3, 1, 1, 1, 1};
    tbl[20] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    tbl[21] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    for (int i = 0; i < 22; i++) begin
      rst_n = tbl[i].rst_n;
      cyc(tbl[i].btn, tbl[i].tick, tbl[i].m1, tbl[i].m2);
      chk($sformatf("vec%0d.state", i), int'(st_a), tbl[i].st);
      chk($sformatf("vec%0d.hold", i), int'(hold_a), int'(tbl[i].hold));
      chk($sformatf("vec%0d.score_p1", i), int'(s1_a), tbl[i].s1);
      chk($sformatf("vec%0d.score_p2", i), int'(s2_a), tbl[i].s2);
      chk($sformatf("vec%0d.serve_dir", i), int'(dir_a), int'(tbl[i].dir));
      chk($sformatf("vec%0d.game_over", i), int'(over_a), 0);
      if (i == 0) chk_en = 1'b1;
    end

    // Short game reaches OVER on its second point; long game keeps going.
    for (int i = 0; i < SD; i++) cyc(0, 1, 0, 0);
    chk("over.play", int'(st_a), 2);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("over.state", int'(st_a), 4);
    chk("over.game_over", int'(over_a), 1);
    chk("over.winner", int'(win_a), 0);
    chk("over.score_p1", int'(s1_a), 2);
    chk("over.long_serve", int'(st_b), 1);
    cyc(0, 0, 1, 0);
    chk("over.frozen_p2", int'(s2_a), 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("restart.state", int'(st_a), 1);
    chk("restart.score_p1", int'(s1_a), 0);
    chk("restart.score_p2", int'(s2_a), 0);
    chk("restart.game_over", int'(over_a), 0);
    chk("restart.long_keeps", int'(s1_b), 2);

    // Mid-play reset with the long game at 3:1.
    for (int i = 0; i < SD; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < SD; i++) cyc(0, 1, 0, 0);
    chk("prerst.state", int'(st_b), 2);
    chk("prerst.score_p1", int'(s1_b), 3);
    chk("prerst.score_p2", int'(s2_b), 1);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    chk("rst.state", int'(st_b), 0);
    chk("rst.score_p1", int'(s1_b), 0);
    chk("rst.score_p2", int'(s2_b), 0);
    chk("rst.hold", int'(hold_b), 1);

    // Start press during play.
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < SD; i++) cyc(0, 1, 0, 0);
    chk("pause.in_play", int'(st_a), 2);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
`ifdef PONG_GAME_CTRL_PAUSE_EN
    chk("pause.state", int'(st_a), 5);
    chk("pause.hold", int'(hold_a), 1);
    cyc(0, 0, 1, 0);
    chk("pause.miss_state", int'(st_a), 5);
    chk("pause.miss_score", int'(s2_a), 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("resume.state", int'(st_a), 2);
    chk("resume.score_p2", int'(s2_a), 0);
`else
    chk("nopause.state", int'(st_a), 2);
    chk("nopause.hold", int'(hold_a), 0);
    cyc(0, 0, 1, 0);
    chk("nopause.point", int'(st_a), 3);
    chk("nopause.score_p2", int'(s2_a), 1);
`endif

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      cyc(($urandom_range(0, 15) == 0) ? ~btn_start : btn_start,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0));
    end
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk_en = 1'b0;
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
